// File: rtl/lb_regs.sv
// Local-bus register slave: CTRL / STATUS / SCRATCH / CNT behind independent
// write and read handshake FSMs with programmable write wait states and read latency.
`timescale 1ns/1ps

module lb_regs #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W/8,
    parameter int RD_LAT  = 1,
    parameter int WR_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wen,
    output logic              wready,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic [31:0]       status_i,
    output logic [31:0]       ctrl_o
);

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_ACK} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ACK} rstate_t;

    wstate_t           wstate;
    rstate_t           rstate;
    logic [1:0]        wcnt;
    logic [1:0]        rcnt;
    logic [DATA_W-1:0] ctrl;
    logic [DATA_W-1:0] scratch;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rcap_p1;
    logic              wmapped;
    logic              unused_addr;

    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] r;
        r = old_val;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return r;
    endfunction

    // Byte-offset bits carry no meaning on a word-aligned map.
    assign unused_addr = ^{raddr[1:0], waddr[1:0]};
    assign wmapped     = (waddr[ADDR_W-1:4] == '0);

    always_comb begin
        rd_val = '0;
        if (raddr[ADDR_W-1:4] == '0) begin
            case (raddr[3:2])
                2'd0:    rd_val = ctrl;
                2'd1:    rd_val = status_i;
                2'd2:    rd_val = scratch;
                default: rd_val = cnt;
            endcase
        end
    end

    // Write side: wready is asserted on entry to W_ACK so it lands 1+WR_WAIT
    // cycles after the request; the register update happens at the ack edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate  <= W_IDLE;
            wcnt    <= '0;
            wready  <= 1'b0;
            ctrl    <= '0;
            scratch <= '0;
            cnt     <= '0;
        end else begin
            wready <= 1'b0;
            if (ctrl[0]) cnt <= cnt + DATA_W'(1);
            case (wstate)
                W_IDLE: begin
                    if (wen) begin
                        if (WR_WAIT == 0) begin
                            wstate <= W_ACK;
                            wready <= 1'b1;
                        end else begin
                            wstate <= W_WAIT;
                            wcnt   <= 2'(WR_WAIT - 1);
                        end
                    end
                end
                W_WAIT: begin
                    if (wcnt == 2'd0) begin
                        wstate <= W_ACK;
                        wready <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 2'd1;
                    end
                end
                W_ACK: begin
                    wstate <= W_IDLE;
                    if (wmapped) begin
                        case (waddr[3:2])
                            2'd0:    ctrl    <= lane_merge(ctrl, wdata, wstrb);
                            2'd2:    scratch <= lane_merge(scratch, wdata, wstrb);
                            2'd3:    cnt     <= '0;
                            default: ;
                        endcase
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read stage p1: value captured at acceptance, held until the ack cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate <= R_IDLE;
            rcnt   <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            case (rstate)
                R_IDLE: begin
                    if (ren) begin
                        if (RD_LAT <= 1) begin
                            rstate <= R_ACK;
                            rvalid <= 1'b1;
                        end else begin
                            rstate <= R_WAIT;
                            rcnt   <= 2'(RD_LAT - 2);
                        end
                    end
                end
                R_WAIT: begin
                    if (rcnt == 2'd0) begin
                        rstate <= R_ACK;
                        rvalid <= 1'b1;
                    end else begin
                        rcnt <= rcnt - 2'd1;
                    end
                end
                R_ACK:   rstate <= R_IDLE;
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstate == R_IDLE && ren) rcap_p1 <= rd_val;
    end

    assign rdata  = rvalid ? rcap_p1 : '0;
    assign ctrl_o = ctrl;

endmodule

// File: tb/tb_lb_regs.sv
// Self-checking bench for lb_regs: two instances (fast and slow timing) driven
// by directed scenarios plus randomized traffic checked against a register-map model.
`timescale 1ns/1ps

module tb_lb_regs;

    localparam int RD_LAT0 = 1, WR_WAIT0 = 0;
    localparam int RD_LAT1 = 4, WR_WAIT1 = 3;

    logic        clk;
    logic        rst;
    logic [31:0] status;
    logic [15:0] waddr [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic        wen   [2];
    logic        wready[2];
    logic [15:0] raddr [2];
    logic        ren   [2];
    logic [31:0] rdata [2];
    logic        rvalid[2];
    logic [31:0] ctrl  [2];

    int vectors;
    int miscompares;
    int cyc;

    lb_regs #(.ADDR_W(16), .DATA_W(32), .STRB_W(4), .RD_LAT(RD_LAT0), .WR_WAIT(WR_WAIT0)) u0 (
        .clk(clk), .rst(rst), .waddr(waddr[0]), .wdata(wdata[0]), .wstrb(wstrb[0]),
        .wen(wen[0]), .wready(wready[0]), .raddr(raddr[0]), .ren(ren[0]),
        .rdata(rdata[0]), .rvalid(rvalid[0]), .status_i(status), .ctrl_o(ctrl[0])
    );

    lb_regs #(.ADDR_W(16), .DATA_W(32), .STRB_W(4), .RD_LAT(RD_LAT1), .WR_WAIT(WR_WAIT1)) u1 (
        .clk(clk), .rst(rst), .waddr(waddr[1]), .wdata(wdata[1]), .wstrb(wstrb[1]),
        .wen(wen[1]), .wready(wready[1]), .raddr(raddr[1]), .ren(ren[1]),
        .rdata(rdata[1]), .rvalid(rvalid[1]), .status_i(status), .ctrl_o(ctrl[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic int exp_wlat(input int s);
        return (s == 0) ? 1 + WR_WAIT0 : 1 + WR_WAIT1;
    endfunction

    function automatic int exp_rlat(input int s);
        return (s == 0) ? RD_LAT0 : RD_LAT1;
    endfunction

    // lat = cycles from first wen to wready, cy = cycle of the ack, extra = later wready pulses
    task automatic do_write(input int s, input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] st, output int lat, output int cy, output int extra);
        @(posedge clk); #1;
        waddr[s] = a; wdata[s] = d; wstrb[s] = st; wen[s] = 1'b1;
        lat = -1; cy = -1; extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wready[s]) begin lat = i; cy = cyc; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        wen[s] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wready[s]) extra++;
        end
    endtask

    task automatic do_read(input int s, input logic [15:0] a, output logic [31:0] d,
                           output int lat, output int cy, output int extra);
        @(posedge clk); #1;
        raddr[s] = a; ren[s] = 1'b1;
        lat = -1; cy = cyc; extra = 0; d = 32'hxxxx_xxxx;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rvalid[s]) begin lat = i; d = rdata[s]; break; end
            vectors++;
            if (rdata[s] !== 32'h0) begin
                miscompares++;
                $display("FAIL rdata_idle inst%0d: got %h want 00000000", s, rdata[s]);
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ren[s] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid[s]) extra++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        logic [31:0] expv [4];
        int lat, cy, ex;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if ({wready[s], rvalid[s]} !== 2'b00 || rdata[s] !== 32'h0 || ctrl[s] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_outputs inst%0d: got wready=%b rvalid=%b rdata=%h ctrl=%h want all 0",
                         s, wready[s], rvalid[s], rdata[s], ctrl[s]);
            end
        end
        expv = '{32'h0, 32'hA5A5_0F0F, 32'h0, 32'h0};
        for (int k = 0; k < 4; k++) begin
            do_read(0, 16'(k * 4), got, lat, cy, ex);
            vectors++;
            if (got !== expv[k] || lat != 1 || ex != 0) begin
                miscompares++;
                $display("FAIL reset_read addr=%h: got data=%h lat=%0d extra=%0d want data=%h lat=1 extra=0",
                         k * 4, got, lat, ex, expv[k]);
            end
        end
    endtask

    task automatic test_scratch();
        logic [31:0] got;
        int lat, cy, ex;
        do_write(0, 16'h8, 32'h1234_5678, 4'hF, lat, cy, ex);
        do_write(0, 16'h8, 32'hFFFF_FFFF, 4'h2, lat, cy, ex);
        do_read(0, 16'h8, got, lat, cy, ex);
        vectors++;
        if (got !== 32'h1234_FF78) begin
            miscompares++;
            $display("FAIL scratch_strobe: got %h want 1234ff78", got);
        end
        do_write(0, 16'h10, 32'hFFFF_FFFF, 4'hF, lat, cy, ex);
        vectors++;
        if (lat != 1 || ctrl[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL unmapped_write: got lat=%0d ctrl=%h want lat=1 ctrl=00000000", lat, ctrl[0]);
        end
        do_read(0, 16'h10, got, lat, cy, ex);
        vectors++;
        if (got !== 32'h0 || lat != 1) begin
            miscompares++;
            $display("FAIL unmapped_read: got data=%h lat=%0d want data=00000000 lat=1", got, lat);
        end
        do_read(0, 16'hA, got, lat, cy, ex);
        vectors++;
        if (got !== 32'h1234_FF78) begin
            miscompares++;
            $display("FAIL scratch_after_unmapped: got %h want 1234ff78", got);
        end
    endtask

    task automatic test_counter();
        logic [31:0] got, expv, diff;
        int lat, acy, rcy, ex, fcy;
        do_write(0, 16'h0, 32'h1, 4'hF, lat, acy, ex);
        vectors++;
        if (ctrl[0] !== 32'h1) begin
            miscompares++;
            $display("FAIL ctrl_enable: got %h want 00000001", ctrl[0]);
        end
        repeat (10) @(posedge clk);
        do_read(0, 16'hC, got, lat, rcy, ex);
        expv = 32'(rcy - acy - 1);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL cnt_run: got %h want %h", got, expv);
        end
        do_write(0, 16'hC, 32'hFFFF_FFFF, 4'h0, lat, acy, ex);
        do_read(0, 16'hC, got, lat, rcy, ex);
        expv = 32'(rcy - acy - 1);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL cnt_clear: got %h want %h", got, expv);
        end
        @(posedge clk); #1;
        force u0.cnt = 32'hFFFF_FFFA;
        @(posedge clk); #1;
        release u0.cnt;
        fcy = cyc;
        repeat (6) @(posedge clk);
        do_read(0, 16'hC, got, lat, rcy, ex);
        expv = 32'hFFFF_FFFA + 32'(rcy - fcy);
        diff = got - expv;
        vectors++;
        if (diff > 32'd1) begin
            miscompares++;
            $display("FAIL cnt_wrap: got %h want %h (or one more)", got, expv);
        end
    endtask

    task automatic test_latency();
        logic [31:0] got;
        int lat, cy, ex;
        do_write(1, 16'h8, 32'hBEEF_0001, 4'hF, lat, cy, ex);
        vectors++;
        if (lat != exp_wlat(1) || ex != 0) begin
            miscompares++;
            $display("FAIL slow_write: got lat=%0d extra=%0d want lat=%0d extra=0", lat, ex, exp_wlat(1));
        end
        do_read(1, 16'h8, got, lat, cy, ex);
        vectors++;
        if (got !== 32'hBEEF_0001 || lat != exp_rlat(1) || ex != 0) begin
            miscompares++;
            $display("FAIL slow_read: got data=%h lat=%0d extra=%0d want data=beef0001 lat=%0d extra=0",
                     got, lat, ex, exp_rlat(1));
        end
        do_write(1, 16'h0, 32'h0000_00AB, 4'h1, lat, cy, ex);
        vectors++;
        if (ctrl[1] !== 32'h0000_00AB) begin
            miscompares++;
            $display("FAIL slow_ctrl: got %h want 000000ab", ctrl[1]);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] got;
        int lat, cy, ex;
        do_write(0, 16'h8, 32'h0, 4'hF, lat, cy, ex);
        @(posedge clk); #1;
        waddr[0] = 16'h8; wdata[0] = 32'h1; wstrb[0] = 4'hF; wen[0] = 1'b1;
        @(posedge clk); #1;
        raddr[0] = 16'h8; ren[0] = 1'b1;
        @(negedge clk);
        vectors++;
        if (wready[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL conflict_wready: got %b want 1", wready[0]);
        end
        @(posedge clk); #1;
        wen[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL conflict_old: got rvalid=%b rdata=%h want rvalid=1 rdata=00000000",
                     rvalid[0], rdata[0]);
        end
        @(posedge clk); #1;
        ren[0] = 1'b0;
        do_read(0, 16'h8, got, lat, cy, ex);
        vectors++;
        if (got !== 32'h1) begin
            miscompares++;
            $display("FAIL conflict_new: got %h want 00000001", got);
        end
    endtask

    task automatic test_random(input int s, input int n);
        logic [31:0] m_ctrl, m_scr, d, got, expv, mask;
        logic [15:0] a;
        logic [3:0]  st;
        int lat, cy, ex;
        do_write(s, 16'h0, 32'h0, 4'hF, lat, cy, ex);
        do_write(s, 16'h8, 32'h0, 4'hF, lat, cy, ex);
        do_write(s, 16'hC, 32'h0, 4'hF, lat, cy, ex);
        m_ctrl = 32'h0;
        m_scr  = 32'h0;
        for (int k = 0; k < n; k++) begin
            a      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {12'h0, 4'($urandom)};
            d      = $urandom;
            st     = 4'($urandom);
            status = $urandom;
            mask   = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
            if ($urandom_range(0, 1) == 1) begin
                if (a < 16'h4) d[0] = 1'b0;
                do_write(s, a, d, st, lat, cy, ex);
                if (a < 16'h4) m_ctrl = (m_ctrl & ~mask) | (d & mask);
                else if (a >= 16'h8 && a < 16'hC) m_scr = (m_scr & ~mask) | (d & mask);
                vectors++;
                if (lat != exp_wlat(s) || ex != 0 || ctrl[s] !== m_ctrl) begin
                    miscompares++;
                    $display("FAIL rand_write inst%0d a=%h: got lat=%0d extra=%0d ctrl=%h want lat=%0d extra=0 ctrl=%h",
                             s, a, lat, ex, ctrl[s], exp_wlat(s), m_ctrl);
                end
            end else begin
                do_read(s, a, got, lat, cy, ex);
                if (a >= 16'h10)      expv = 32'h0;
                else if (a < 16'h4)   expv = m_ctrl;
                else if (a < 16'h8)   expv = status;
                else if (a < 16'hC)   expv = m_scr;
                else                  expv = 32'h0;
                vectors++;
                if (got !== expv || lat != exp_rlat(s) || ex != 0) begin
                    miscompares++;
                    $display("FAIL rand_read inst%0d a=%h: got data=%h lat=%0d extra=%0d want data=%h lat=%0d extra=0",
                             s, a, got, lat, ex, expv, exp_rlat(s));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        int lat, cy, ex, pulses;
        do_write(1, 16'h0, 32'h5, 4'hF, lat, cy, ex);
        do_write(1, 16'h8, 32'h0000_CAFE, 4'hF, lat, cy, ex);
        @(posedge clk); #1;
        waddr[1] = 16'h8; wdata[1] = 32'hDEAD_BEEF; wstrb[1] = 4'hF; wen[1] = 1'b1;
        raddr[1] = 16'h8; ren[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wen[1] = 1'b0; ren[1] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wready[1]) pulses++;
            if (rvalid[1]) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL reset_abort_pulses: got %0d want 0", pulses);
        end
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if ({wready[s], rvalid[s]} !== 2'b00 || rdata[s] !== 32'h0 || ctrl[s] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_mid_outputs inst%0d: got wready=%b rvalid=%b rdata=%h ctrl=%h want all 0",
                         s, wready[s], rvalid[s], rdata[s], ctrl[s]);
            end
        end
        do_read(1, 16'h8, got, lat, cy, ex);
        vectors++;
        if (got !== 32'h0 || lat != exp_rlat(1)) begin
            miscompares++;
            $display("FAIL reset_mid_scratch: got data=%h lat=%0d want data=00000000 lat=%0d", got, lat, exp_rlat(1));
        end
        do_read(0, 16'hC, got, lat, cy, ex);
        vectors++;
        if (got !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_cnt: got %h want 00000000", got);
        end
        do_write(1, 16'h8, 32'h0000_600D, 4'hF, lat, cy, ex);
        vectors++;
        if (lat != exp_wlat(1)) begin
            miscompares++;
            $display("FAIL reset_mid_rewrite: got lat=%0d want %0d", lat, exp_wlat(1));
        end
        do_read(1, 16'h8, got, lat, cy, ex);
        vectors++;
        if (got !== 32'h0000_600D) begin
            miscompares++;
            $display("FAIL reset_mid_readback: got %h want 0000600d", got);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        status      = 32'hA5A5_0F0F;
        for (int s = 0; s < 2; s++) begin
            waddr[s] = '0; wdata[s] = '0; wstrb[s] = '0; wen[s] = 1'b0;
            raddr[s] = '0; ren[s] = 1'b0;
        end
        test_reset();
        test_scratch();
        test_counter();
        test_latency();
        test_conflict();
        test_random(0, 60);
        test_random(1, 40);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
